// File: rtl/proc_pkg.sv
// Shared definitions for the fetch/decode front end: opcode map, instruction field layout
// and fetch FSM encoding.
package proc_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_LW   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_BEQ  = 4'd10;
  localparam logic [3:0] OP_JMP  = 4'd11;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam int unsigned OpcodeLsb = 12;
  localparam int unsigned OpcodeW   = 4;
  localparam int unsigned RdLsb     = 9;
  localparam int unsigned RsLsb     = 6;
  localparam int unsigned RtLsb     = 3;
  localparam int unsigned ShamtLsb  = 0;
  localparam int unsigned RegW      = 3;
  localparam int unsigned ConstW    = 6;
  localparam int unsigned AddrW     = 8;

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StDrop,
    StHalt
  } fetch_state_e;

  typedef struct packed {
    logic [OpcodeW-1:0] opcode;
    logic [RegW-1:0]    rd;
    logic [RegW-1:0]    rs;
    logic [RegW-1:0]    rt;
    logic [RegW-1:0]    shamt;
    logic [ConstW-1:0]  constant;
    logic [AddrW-1:0]   address;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
  } decoded_t;

  // Opcodes 12..14 have no defined meaning.
  function automatic logic is_reserved(logic [OpcodeW-1:0] op);
    return (op >= 4'd12) && (op <= 4'd14);
  endfunction

endpackage

// File: rtl/fetch_decode_stage_if.sv
// Instruction-memory, IF/ID slot and redirect signals of the fetch/decode stage.
// FETCH_ILLEGAL_TRAP_EN adds the illegal_op flag.
interface fetch_decode_stage_if #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         opcode;
  logic [2:0]         rd;
  logic [2:0]         rs;
  logic [2:0]         rt;
  logic [2:0]         shamt;
  logic [5:0]         constant;
  logic [7:0]         address;
  logic [PC_W-1:0]    pc;
  logic               mem_read;
  logic               mem_write;
  logic               reg_write;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               halted;
`ifdef FETCH_ILLEGAL_TRAP_EN
  logic               illegal_op;
`endif

  modport master (
    output imem_req, imem_addr, out_valid, opcode, rd, rs, rt, shamt, constant, address, pc,
           mem_read, mem_write, reg_write, halted,
`ifdef FETCH_ILLEGAL_TRAP_EN
    output illegal_op,
`endif
    input  imem_rdata, imem_valid, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, opcode, rd, rs, rt, shamt, constant, address, pc,
           mem_read, mem_write, reg_write, halted,
`ifdef FETCH_ILLEGAL_TRAP_EN
    input  illegal_op,
`endif
    output imem_rdata, imem_valid, out_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/instr_decoder.sv
// Combinational decode of a 16-bit instruction word into operand fields and control strobes.
module instr_decoder
  import proc_pkg::*;
(
  input  logic [15:0] instr,
  output decoded_t    dec
);

  logic [OpcodeW-1:0] op;

  assign op = instr[OpcodeLsb +: OpcodeW];

  always_comb begin
    dec           = '0;
    dec.opcode    = op;
    dec.rd        = instr[RdLsb +: RegW];
    dec.rs        = instr[RsLsb +: RegW];
    dec.rt        = instr[RtLsb +: RegW];
    dec.shamt     = instr[ShamtLsb +: RegW];
    dec.constant  = instr[ConstW-1:0];
    dec.address   = instr[AddrW-1:0];
    dec.mem_read  = (op == OP_LW);
    dec.mem_write = (op == OP_SW);
    // ADD..LW write the register file; MUL targets hi/lo only.
    dec.reg_write = (op <= OP_LW);
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch/decode front end: request/valid instruction fetch, decode, registered IF/ID slot,
// redirect and HALT. Define FETCH_ILLEGAL_TRAP_EN to halt on reserved opcodes 12..14.
module fetch_decode_stage
  import proc_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic                  clk,
  input logic                  rst,
  fetch_decode_stage_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, slot_pc_q, slot_pc_d;
  decoded_t        slot_q, slot_d, dec;
  logic            out_valid_q, out_valid_d;
  logic            halted_q, halted_d;
  logic            slot_free, stop_op;

  instr_decoder u_decoder (
    .instr (bus.imem_rdata),
    .dec   (dec)
  );

`ifdef FETCH_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign stop_op        = (dec.opcode == OP_HALT) || is_reserved(dec.opcode);
  assign bus.illegal_op = illegal_q;
`else
  assign stop_op = (dec.opcode == OP_HALT);
`endif

  assign slot_free = ~out_valid_q | bus.out_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    slot_d      = slot_q;
    slot_pc_d   = slot_pc_q;
    out_valid_d = out_valid_q;
    halted_d    = halted_q;
`ifdef FETCH_ILLEGAL_TRAP_EN
    illegal_d   = illegal_q;
`endif
    bus.imem_req = 1'b0;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      StFetch: begin
        // A redirect this cycle would make the fetched word stale, so hold off the request.
        if (slot_free && !bus.redirect_valid && !rst) begin
          bus.imem_req = 1'b1;
          state_d      = StWait;
        end
      end
      StWait: begin
        bus.imem_req = 1'b1;
        if (bus.imem_valid) begin
          if (stop_op) begin
            state_d  = StHalt;
            halted_d = 1'b1;
`ifdef FETCH_ILLEGAL_TRAP_EN
            illegal_d = is_reserved(dec.opcode);
`endif
          end else begin
            state_d     = StFetch;
            out_valid_d = 1'b1;
            slot_d      = dec;
            slot_pc_d   = pc_q;
            pc_d        = pc_q + PC_W'(1);
          end
        end
      end
      StDrop: begin
        if (bus.imem_valid) state_d = StFetch;
      end
      StHalt: begin
      end
      default: state_d = StFetch;
    endcase

    // Redirect wins over everything. A response arriving in the same cycle is discarded
    // right away, so there is nothing left to drop.
    if (bus.redirect_valid) begin
      pc_d        = bus.redirect_pc;
      out_valid_d = 1'b0;
      halted_d    = 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
      illegal_d   = 1'b0;
`endif
      if ((state_q == StWait || state_q == StDrop) && !bus.imem_valid) state_d = StDrop;
      else state_d = StFetch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      slot_q      <= '0;
      slot_pc_q   <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      slot_q      <= slot_d;
      slot_pc_q   <= slot_pc_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
`ifdef FETCH_ILLEGAL_TRAP_EN
      illegal_q   <= illegal_d;
`endif
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.opcode    = slot_q.opcode;
  assign bus.rd        = slot_q.rd;
  assign bus.rs        = slot_q.rs;
  assign bus.rt        = slot_q.rt;
  assign bus.shamt     = slot_q.shamt;
  assign bus.constant  = slot_q.constant;
  assign bus.address   = slot_q.address;
  assign bus.pc        = slot_pc_q;
  assign bus.mem_read  = slot_q.mem_read;
  assign bus.mem_write = slot_q.mem_write;
  assign bus.reg_write = slot_q.reg_write;
  assign bus.halted    = halted_q;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: decode vectors, hand-written handshake/redirect/HALT sequences
// and a randomized run against a transaction-level fetch/emit scoreboard.
module tb_fetch_decode_stage;
  import proc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_decode_stage_if #(.PC_W(8), .INSTR_W(16)) bus ();

  fetch_decode_stage #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef FETCH_ILLEGAL_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_word();
    logic [3:0] op;
    op = 4'($urandom_range(0, 11));
    return {op, 12'($urandom)};
  endfunction

  function automatic logic [31:0] dut_fields();
    return 32'({bus.opcode, bus.rd, bus.rs, bus.rt, bus.shamt, bus.constant, bus.address});
  endfunction

  // Instruction memory: one outstanding request, response after next_lat cycles.
  logic [15:0] mem [256];
  int          lat_cfg = 1;
  bit          lat_rand = 1'b0;
  int          next_lat = 1;
  logic        mem_busy;
  int          mem_cnt;
  logic [7:0]  mem_addr_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_busy       <= 1'b0;
      mem_cnt        <= 0;
      mem_addr_q     <= 8'h00;
      bus.imem_valid <= 1'b0;
      bus.imem_rdata <= 16'h0000;
    end else begin
      bus.imem_valid <= 1'b0;
      if (mem_busy) begin
        if (mem_cnt <= 1) begin
          bus.imem_valid <= 1'b1;
          bus.imem_rdata <= mem[mem_addr_q];
          mem_busy       <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end else if (bus.imem_req && !bus.imem_valid) begin
        if (next_lat <= 1) begin
          bus.imem_valid <= 1'b1;
          bus.imem_rdata <= mem[bus.imem_addr];
        end else begin
          mem_busy   <= 1'b1;
          mem_cnt    <= next_lat - 1;
          mem_addr_q <= bus.imem_addr;
        end
      end
    end
  end

  // Scoreboard: expected fetch address stream and expected emissions, sampled late in each
  // cycle to see what the coming edge will do.
  typedef struct {
    logic [7:0]  pc;
    logic [15:0] w;
  } emit_t;

  emit_t      exp_q[$];
  emit_t      e;
  logic [7:0] exp_fetch, sb_addr;
  logic       sb_out, sb_stale, halted_m, illegal_m;
  int         op, epack;

  initial begin
    forever begin
      @(negedge clk);
      #4;
      next_lat = lat_rand ? int'($urandom_range(1, 4)) : lat_cfg;
      if (rst) begin
        exp_q.delete();
        exp_fetch = 8'h00;
        sb_out    = 1'b0;
        sb_stale  = 1'b0;
        halted_m  = 1'b0;
        illegal_m = 1'b0;
      end else begin
        check("halted", 32'(bus.halted), 32'(halted_m));
`ifdef FETCH_ILLEGAL_TRAP_EN
        check("illegal_op", 32'(bus.illegal_op), 32'(illegal_m));
`endif
        if (bus.imem_valid) begin
          if (!sb_stale && !bus.redirect_valid) begin
            op = int'(bus.imem_rdata) >> 12;
            if (op == 15 || (Trap && op >= 12 && op <= 14)) begin
              halted_m  = 1'b1;
              illegal_m = (op != 15);
            end else begin
              exp_q.push_back('{pc: sb_addr, w: bus.imem_rdata});
              exp_fetch = sb_addr + 8'd1;
            end
          end
          sb_out   = 1'b0;
          sb_stale = 1'b0;
        end
        if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL emission: got pc 0x%0h, expected no instruction", bus.pc);
          end else begin
            e = exp_q.pop_front();
            op = int'(e.w) >> 12;
            epack = (op << 26) | (((int'(e.w) >> 9) & 7) << 23) | (((int'(e.w) >> 6) & 7) << 20)
                  | (((int'(e.w) >> 3) & 7) << 17) | ((int'(e.w) & 7) << 14)
                  | ((int'(e.w) & 63) << 8) | (int'(e.w) & 255);
            check("emit_pc", 32'(bus.pc), 32'(e.pc));
            check("emit_fields", dut_fields(), epack);
            check("emit_strobes", 32'({bus.mem_read, bus.mem_write, bus.reg_write}),
                  32'({op == 7, op == 8, op < 8}));
          end
        end
        if (bus.out_valid && !bus.out_ready && !sb_out)
          check("req_while_full", 32'(bus.imem_req), 32'(0));
        if (bus.imem_req && !bus.imem_valid && !sb_out) begin
          check("fetch_addr", 32'(bus.imem_addr), 32'(exp_fetch));
          sb_out  = 1'b1;
          sb_addr = bus.imem_addr;
        end
        if (bus.redirect_valid) begin
          exp_q.delete();
          exp_fetch = bus.redirect_pc;
          if (sb_out) sb_stale = 1'b1;
          halted_m  = 1'b0;
          illegal_m = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [15:0] w;
    logic [3:0]  op;
    logic [2:0]  rd, rs, rt, sh;
    logic [5:0]  k;
    logic [7:0]  a;
    logic        mr, mw, rw;
  } vec_t;

  vec_t vec[8];
  bit   seen_valid;

  task automatic redirect_to(input logic [7:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
  endtask

  initial begin
    vec[0] = '{16'h7241, 4'd7,  3'd1, 3'd1, 3'd0, 3'd1, 6'h01, 8'h41, 1'b1, 1'b0, 1'b1};
    vec[1] = '{16'h8A5C, 4'd8,  3'd5, 3'd1, 3'd3, 3'd4, 6'h1C, 8'h5C, 1'b0, 1'b1, 1'b0};
    vec[2] = '{16'h0000, 4'd0,  3'd0, 3'd0, 3'd0, 3'd0, 6'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vec[3] = '{16'h9FFF, 4'd9,  3'd7, 3'd7, 3'd7, 3'd7, 6'h3F, 8'hFF, 1'b0, 1'b0, 1'b0};
    vec[4] = '{16'h6123, 4'd6,  3'd0, 3'd4, 3'd4, 3'd3, 6'h23, 8'h23, 1'b0, 1'b0, 1'b1};
    vec[5] = '{16'hB0FE, 4'd11, 3'd0, 3'd3, 3'd7, 3'd6, 6'h3E, 8'hFE, 1'b0, 1'b0, 1'b0};
    vec[6] = '{16'h3E07, 4'd3,  3'd7, 3'd0, 3'd0, 3'd7, 6'h07, 8'h07, 1'b0, 1'b0, 1'b1};
    vec[7] = '{16'hA000, 4'd10, 3'd0, 3'd0, 3'd0, 3'd0, 6'h00, 8'h00, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 8'h00;
    for (int a = 0; a < 256; a++) mem[a] = rand_word();
    for (int i = 0; i < 8; i++) mem[i] = vec[i].w;
    mem[8'h30] = 16'hF000;
    mem[8'h40] = 16'hD123;
    mem[8'hFF] = 16'h0000;
    repeat (2) tick();

    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_imem_req", 32'(bus.imem_req), 32'(0));
    check("rst_halted", 32'(bus.halted), 32'(0));
    check("rst_strobes", 32'({bus.mem_read, bus.mem_write, bus.reg_write}), 32'(0));
    check("rst_fields", dut_fields(), 32'(0));
    check("rst_pc", 32'(bus.pc), 32'(0));
    check("rst_imem_addr", 32'(bus.imem_addr), 32'(0));
`ifdef FETCH_ILLEGAL_TRAP_EN
    check("rst_illegal_op", 32'(bus.illegal_op), 32'(0));
`endif

    rst = 1'b0;
    #1;
    check("first_req", 32'({bus.imem_req, bus.imem_addr}), 32'({1'b1, 8'h00}));

    for (int i = 0; i < 8; i++) begin
      tick();
      for (int n = 0; n < 20 && !bus.out_valid; n++) tick();
      check("vec_valid", 32'(bus.out_valid), 32'(1));
      check("vec_pc", 32'(bus.pc), 32'(i));
      check("vec_fields", dut_fields(),
            32'({vec[i].op, vec[i].rd, vec[i].rs, vec[i].rt, vec[i].sh, vec[i].k, vec[i].a}));
      check("vec_strobes", 32'({bus.mem_read, bus.mem_write, bus.reg_write}),
            32'({vec[i].mr, vec[i].mw, vec[i].rw}));
      if (i == 0) check("next_fetch", 32'({bus.imem_req, bus.imem_addr}), 32'({1'b1, 8'h01}));
    end

    // Back-pressure with the slot full.
    bus.out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("stall_req", 32'(bus.imem_req), 32'(0));
      check("stall_slot", 32'({bus.out_valid, bus.opcode, bus.pc}), 32'({1'b1, 4'd10, 8'h07}));
    end
    bus.out_ready = 1'b1;
    lat_cfg = 4;
    #1;
    check("stall_release", 32'({bus.imem_req, bus.imem_addr}), 32'({1'b1, 8'h08}));

    // Redirect while waiting on a slow response: the response must be dropped.
    tick();
    redirect_to(8'h20);
    for (int n = 0; n < 3; n++) begin
      check("drop_quiet", 32'({bus.imem_req, bus.out_valid}), 32'(0));
      tick();
    end
    lat_cfg = 1;
    for (int n = 0; n < 10 && !bus.imem_req; n++) tick();
    check("drop_refetch", 32'({bus.imem_req, bus.out_valid, bus.imem_addr}),
          32'({1'b1, 1'b0, 8'h20}));

    // PC wrap.
    tick();
    redirect_to(8'hFF);
    for (int n = 0; n < 20 && !bus.out_valid; n++) tick();
    check("wrap_pc", 32'({bus.out_valid, bus.pc}), 32'({1'b1, 8'hFF}));
    check("wrap_next", 32'({bus.imem_req, bus.imem_addr}), 32'({1'b1, 8'h00}));

    // HALT.
    tick();
    redirect_to(8'h30);
    seen_valid = 1'b0;
    for (int n = 0; n < 20 && !bus.halted; n++) begin
      tick();
      seen_valid |= bus.out_valid;
    end
    check("halt_entered", 32'({bus.halted, seen_valid}), 32'({1'b1, 1'b0}));
    for (int n = 0; n < 10; n++) begin
      tick();
      check("halt_idle", 32'({bus.imem_req, bus.out_valid, bus.halted}), 32'(3'b001));
    end
    redirect_to(8'h05);
    check("halt_exit", 32'({bus.halted, bus.imem_req, bus.imem_addr}), 32'({2'b01, 8'h05}));

    // Reserved opcode 13.
    tick();
    redirect_to(8'h40);
`ifdef FETCH_ILLEGAL_TRAP_EN
    seen_valid = 1'b0;
    for (int n = 0; n < 20 && !bus.halted; n++) begin
      tick();
      seen_valid |= bus.out_valid;
    end
    check("trap", 32'({bus.illegal_op, bus.halted, seen_valid}), 32'(3'b110));
    redirect_to(8'h50);
    check("trap_clear", 32'({bus.illegal_op, bus.halted}), 32'(0));
`else
    for (int n = 0; n < 20 && !bus.out_valid; n++) tick();
    check("nop13", 32'({bus.out_valid, bus.opcode, bus.pc}), 32'({1'b1, 4'd13, 8'h40}));
    check("nop13_strobes", 32'({bus.mem_read, bus.mem_write, bus.reg_write}), 32'(0));
`endif

    // Randomized traffic: back-pressure, latencies 1..4, redirects and occasional resets.
    for (int a = 0; a < 256; a++) mem[a] = rand_word();
    lat_rand = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      tick();
      bus.out_ready      = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 40) == 0);
      bus.redirect_pc    = 8'($urandom);
      rst = rst ? 1'b0 : ($urandom_range(0, 600) == 0);
    end
    tick();
    rst = 1'b0;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Front-end stage directly upstream of the datapath.
- Fetches 16-bit instructions from an 8-bit-addressed instruction memory through a request/valid handshake.
- Decodes each instruction into the datapath's operand fields (opcode, rd, rs, rt, shamt, constant, address, pc) and its control strobes (mem_read, mem_write, reg_write).
- Presents the decoded result in a registered IF/ID slot with valid/ready flow control, and supports branch redirect and HALT.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- PC_W, 8, PC and instruction-memory address width.
- INSTR_W, 16, instruction width.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request, held high until imem_valid.
- imem_addr  out  8  fetch address; equals the PC register while imem_req=1.
- imem_rdata  in  16  instruction word, sampled when imem_valid=1.
- imem_valid  in  1  response strobe, one cycle, any latency of 1 cycle or more after the request.
- out_valid  out  1  IF/ID slot holds a decoded instruction.
- out_ready  in  1  datapath accepts the slot this cycle.
- opcode  out  4  instruction bits [15:12].
- rd  out  3  bits [11:9].
- rs  out  3  bits [8:6].
- rt  out  3  bits [5:3].
- shamt  out  3  bits [2:0].
- constant  out  6  bits [5:0].
- address  out  8  bits [7:0].
- pc  out  8  address of the instruction in the slot.
- mem_read  out  1  high for opcode 7 (LW).
- mem_write  out  1  high for opcode 8 (SW).
- reg_write  out  1  high for opcodes 0–7.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  8  target PC.
- halted  out  1  stage stopped on HALT.

Behaviour:
- Reset (rst=1, asynchronous):
  - PC register = RESET_PC; state = FETCH.
  - out_valid, imem_req, halted, mem_read, mem_write, reg_write = 0.
  - All field outputs = 0.
- Opcode map:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 ADDI, 7 LW, 8 SW, 9 MUL (hi/lo only, reg_write=0), 10 BEQ, 11 JMP, 12–14 reserved, 15 HALT.
  - Fields are sliced unconditionally; interpreting them is the datapath's job.
- State FETCH:
  - Issues a request only when the slot is free: out_valid=0, or out_valid=1 with out_ready=1 in the same cycle.
  - On issue: imem_req=1, imem_addr=PC, go to WAIT.
- State WAIT:
  - imem_req stays 1.
  - On imem_valid: load the slot (out_valid=1, fields, control strobes, pc=PC), PC <= PC+1 with 8-bit wrap (0xFF to 0x00), go to FETCH.
  - The slot is always empty in WAIT, so capture never stalls.
- Throughput and latency:
  - Best case is 1 instruction per 2 cycles for 1-cycle memory latency.
  - Decoded outputs appear on the edge on which imem_valid is sampled.
- Slot consumption: out_valid & out_ready clears out_valid on the next edge unless the slot is reloaded that edge.
- HALT (opcode 15):
  - Not emitted: out_valid stays 0.
  - PC is held at the HALT address; halted=1; go to HALT state; imem_req=0.
  - Leaves HALT only on rst or redirect_valid.
- redirect_valid=1 has highest priority over every other event, including out_ready and imem_valid in the same cycle:
  - PC <= redirect_pc; out_valid <= 0; halted <= 0.
  - If in WAIT, go to DROP; otherwise go to FETCH.
- State DROP:
  - imem_req=0; waits for the stale imem_valid, discards it, then goes to FETCH.
  - A further redirect while in DROP updates PC and stays in DROP.
- Reset mid-operation: the in-flight response is abandoned. The memory model must not deliver imem_valid for a request cut off by reset.

Optional Feature:
- Macro: FETCH_ILLEGAL_TRAP_EN.
- Defined:
  - Opcodes 12–14 are not emitted.
  - Output illegal_op (1 bit, reset 0) is set; the stage enters HALT with PC held at the faulting address.
  - illegal_op clears only on reset or redirect.
- Undefined:
  - Opcodes 12–14 are emitted as NOPs: mem_read=mem_write=reg_write=0, fields passed through.
  - No illegal_op port.

Decomposition:
- Package proc_pkg:
  - opcode localparams (OP_ADD through OP_HALT);
  - field bit positions and widths;
  - fetch state encoding (FETCH, WAIT, DROP, HALT).
- Sub-module instr_decoder: purely combinational; maps a 16-bit word to fields and control strobes. It is instantiated once and registered in this stage.

Test Plan:
- Reset with RESET_PC=8'h00, memory returning 16'h7241 (LW rd=1, rs=1, address=0x41) at address 0 with 1-cycle latency, out_ready=1 -> imem_addr=0, then out_valid=1, opcode=7, rd=1, rs=1, address=8'h41, mem_read=1, reg_write=1, pc=0; next fetch uses imem_addr=1.
- out_ready=0 for 5 cycles with the slot full -> imem_req stays 0, outputs stay stable; after out_ready=1, the next fetch issues in the same cycle.
- redirect_valid=1, redirect_pc=8'h20 while in WAIT, then imem_valid arrives 3 cycles later -> the response is discarded, out_valid=0, next imem_addr=8'h20.
- PC=8'hFF fetches 16'h0000 -> the emitted pc=8'hFF, next imem_addr=8'h00.
- Fetch of 16'hF000 -> halted=1, no emission, imem_req=0 for 10 cycles; redirect to 8'h05 -> halted=0, imem_addr=8'h05.
- Fetch of opcode 13: with FETCH_ILLEGAL_TRAP_EN -> illegal_op=1, halted=1; without it -> emitted as a NOP with all strobes 0.
